// File: rtl/logic_depth_pkg.sv
// ---------------------------------------------------------------------------
// logic_depth_pkg
// Shared types for the logic-depth path tools.
//   DEPTH_W        : width of one per-gate predicted depth.
//   gate_type_t    : 2-bit gate type carried alongside each depth beat.
//   acc_state_t    : path accumulator FSM states.
//   path_result_t  : one completed path. Field widths are fixed upper bounds,
//                    so users zero-extend narrower values into them
//                    (ACC_W <= 16, count width <= 8, ID_W <= 16).
// ---------------------------------------------------------------------------
package logic_depth_pkg;

  localparam int DEPTH_W   = 4;
  localparam int RES_ACC_W = 16;
  localparam int RES_CNT_W = 8;
  localparam int RES_ID_W  = 16;

  typedef enum logic [1:0] {
    GT_AND = 2'd0,
    GT_OR  = 2'd1,
    GT_XOR = 2'd2,
    GT_INV = 2'd3
  } gate_type_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic [RES_ACC_W-1:0] depth;
    logic [RES_CNT_W-1:0] count;
    logic [DEPTH_W-1:0]   max_stage;
    logic                 violation;
    logic                 overflow;
    logic                 truncated;
    logic [RES_ID_W-1:0]  id;
  } path_result_t;

endpackage

// File: rtl/depth_stat_tracker.sv
// ---------------------------------------------------------------------------
// depth_stat_tracker
// Running worst-path statistics, updated on each result load.
//   clk_i, rst_i     : clock, synchronous active-high reset.
//   load_i           : a new path result is being loaded this cycle.
//   res_i            : the result being loaded.
//   worst_depth_o    : largest path depth seen (ties keep the earlier path).
//   worst_id_o       : ID of that path.
//   viol_cnt_o       : count of violating paths, saturating at 255.
// ---------------------------------------------------------------------------
module depth_stat_tracker
  import logic_depth_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int ID_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  path_result_t     res_i,
  output logic [ACC_W-1:0] worst_depth_o,
  output logic [ID_W-1:0]  worst_id_o,
  output logic [7:0]       viol_cnt_o
);

  logic [ACC_W-1:0] worst_depth_q;
  logic [ID_W-1:0]  worst_id_q;
  logic [7:0]       viol_cnt_q;

  // Only some fields (and only the low bits of the wide ones) matter here.
  logic unused_res;
  assign unused_res = ^res_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      worst_depth_q <= '0;
      worst_id_q    <= '0;
      viol_cnt_q    <= '0;
    end else if (load_i) begin
      // Strictly greater: a tie keeps the earlier path.
      if (res_i.depth[ACC_W-1:0] > worst_depth_q) begin
        worst_depth_q <= res_i.depth[ACC_W-1:0];
        worst_id_q    <= res_i.id[ID_W-1:0];
      end
      if (res_i.violation && (viol_cnt_q != 8'hFF)) begin
        viol_cnt_q <= viol_cnt_q + 8'd1;
      end
    end
  end

  assign worst_depth_o = worst_depth_q;
  assign worst_id_o    = worst_id_q;
  assign viol_cnt_o    = viol_cnt_q;

endmodule

// File: rtl/depth_path_accumulator.sv
// ---------------------------------------------------------------------------
// depth_path_accumulator
// Sums a stream of per-gate predicted depths into per-path results.
//   clk, rst            : clock, synchronous active-high reset.
//   in_valid/in_ready   : gate beat handshake; beat taken when both are 1.
//   in_depth            : predicted depth of one gate.
//   in_gate_type        : gate type, sampled but not used arithmetically.
//   in_last             : closes the current path.
//   cfg_limit           : violation threshold, stable while a path is open.
//   out_valid/out_ready : result handshake; result taken when both are 1.
//   out_path_depth      : saturated depth sum of the path.
//   out_gate_count      : gates in the path.
//   out_max_stage       : largest single gate depth in the path.
//   out_violation       : out_path_depth > cfg_limit at close time.
//   out_overflow        : the sum saturated somewhere along the path.
//   out_truncated       : path was closed by MAX_LEN rather than in_last.
//   out_path_id         : sequence number of the path (wraps).
//   stat_worst_depth/id : worst emitted path and its ID.
//   stat_viol_cnt       : violating paths, saturating at 255.
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// valid never waits on ready, and a held result stays stable until taken.
// ---------------------------------------------------------------------------
module depth_path_accumulator
  import logic_depth_pkg::*;
#(
  parameter int ACC_W   = 8,
  parameter int MAX_LEN = 16,
  parameter int ID_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_depth,
  input  logic [1:0]                   in_gate_type,
  input  logic                         in_last,
  input  logic [ACC_W-1:0]             cfg_limit,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_path_depth,
  output logic [$clog2(MAX_LEN+1)-1:0] out_gate_count,
  output logic [3:0]                   out_max_stage,
  output logic                         out_violation,
  output logic                         out_overflow,
  output logic                         out_truncated,
  output logic [ID_W-1:0]              out_path_id,
  output logic [ACC_W-1:0]             stat_worst_depth,
  output logic [ID_W-1:0]              stat_worst_id,
  output logic [7:0]                   stat_viol_cnt
);

  localparam int CNT_W = $clog2(MAX_LEN+1);

  acc_state_t         state_q;
  logic [ACC_W-1:0]   sum_q, sum_d, sum_base;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
  logic [DEPTH_W-1:0] max_q, max_d, max_base;
  logic               ovf_q, ovf_d, ovf_base;
  logic [ID_W-1:0]    id_q;
  logic               out_valid_q;
  path_result_t       res_q, res_d;
  logic [ACC_W:0]     sum_wide;
  logic               fresh, close, beat, load;

  // Stall only while a result is pending and not being taken this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign beat     = in_valid && in_ready;
  assign load     = beat && close;

  always_comb begin
    // A beat taken in IDLE starts a fresh path, so the running values are
    // replaced by zeros before the beat is folded in.
    fresh    = (state_q == ST_IDLE);
    sum_base = fresh ? '0 : sum_q;
    cnt_base = fresh ? '0 : cnt_q;
    max_base = fresh ? '0 : max_q;
    ovf_base = fresh ? 1'b0 : ovf_q;

    sum_wide = {1'b0, sum_base} + (ACC_W+1)'(in_depth);
    sum_d    = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    ovf_d    = ovf_base | sum_wide[ACC_W];
    cnt_d    = cnt_base + CNT_W'(1);
    max_d    = (in_depth > max_base) ? in_depth : max_base;
    close    = in_last || (cnt_d == CNT_W'(MAX_LEN));

    res_d           = '0;
    res_d.depth     = RES_ACC_W'(sum_d);
    res_d.count     = RES_CNT_W'(cnt_d);
    res_d.max_stage = max_d;
    res_d.violation = (sum_d > cfg_limit);
    res_d.overflow  = ovf_d;
    res_d.truncated = !in_last;
    res_d.id        = RES_ID_W'(id_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sum_q       <= '0;
      cnt_q       <= '0;
      max_q       <= '0;
      ovf_q       <= 1'b0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (beat) begin
        if (close) begin
          // A load in the same cycle as a take overrides the clear above.
          state_q     <= ST_IDLE;
          res_q       <= res_d;
          out_valid_q <= 1'b1;
          id_q        <= id_q + ID_W'(1);
        end else begin
          state_q <= ST_ACCUM;
          sum_q   <= sum_d;
          cnt_q   <= cnt_d;
          max_q   <= max_d;
          ovf_q   <= ovf_d;
        end
      end
    end
  end

  depth_stat_tracker #(
    .ACC_W (ACC_W),
    .ID_W  (ID_W)
  ) u_stats (
    .clk_i         (clk),
    .rst_i         (rst),
    .load_i        (load),
    .res_i         (res_d),
    .worst_depth_o (stat_worst_depth),
    .worst_id_o    (stat_worst_id),
    .viol_cnt_o    (stat_viol_cnt)
  );

  // Gate type is carried on the bus only; wide result fields are padded.
  logic unused_misc;
  assign unused_misc = ^{in_gate_type, res_q};

  assign out_valid      = out_valid_q;
  assign out_path_depth = res_q.depth[ACC_W-1:0];
  assign out_gate_count = res_q.count[CNT_W-1:0];
  assign out_max_stage  = res_q.max_stage;
  assign out_violation  = res_q.violation;
  assign out_overflow   = res_q.overflow;
  assign out_truncated  = res_q.truncated;
  assign out_path_id    = res_q.id[ID_W-1:0];

endmodule
